// File: rtl/mem_pkg.sv
// Shared defaults and controller state encoding for the memory sequencer slice.
package mem_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned RD_LAT = 1;

   typedef enum logic [1:0] {
      FILL,
      WIPE,
      RD_WAIT
   } state_t;

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Command/response bus between the sequencer (master) and the dual-port memory block (slave).
interface mem_seq_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);

   logic [ADDR_W-1:0] mem_addr_a;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [DATA_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_b;
   logic              mem_rw;
   logic              mem_wipe;
   logic [DATA_W-1:0] mem_a_out;
   logic [DATA_W-1:0] mem_b_out;

   modport master (
      output mem_addr_a, mem_addr_b, mem_a, mem_b, mem_rw, mem_wipe,
      input  mem_a_out, mem_b_out
   );

   modport slave (
      input  mem_addr_a, mem_addr_b, mem_a, mem_b, mem_rw, mem_wipe,
      output mem_a_out, mem_b_out
   );

endinterface

// File: rtl/mem_fill_ptr.sv
// Write pointer with a saturating fill count; increments are ignored once full.
module mem_fill_ptr #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W:0]   count,
   output logic              full
);

   localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

   assign full = (count == FULL_CNT);

   // Pointer wraps to 0 on the final write, so it rests at 0 while full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         count <= '0;
      end else if (clr) begin
         ptr   <= '0;
         count <= '0;
      end else if (inc && !full) begin
         ptr   <= ptr + ADDR_W'(1);
         count <= count + (ADDR_W+1)'(1);
      end
   end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Sequencer turning a write-pair stream and read requests into registered memory commands.
module mem_seq_ctrl #(
   parameter int unsigned DATA_W = mem_pkg::DATA_W,
   parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
   parameter int unsigned DEPTH  = mem_pkg::DEPTH,
   parameter int unsigned RD_LAT = mem_pkg::RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wipe_req,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_a,
   input  logic [DATA_W-1:0] wr_b,
   input  logic              rd_req,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   output logic [ADDR_W:0]   wr_count,
   output logic              full,
   mem_seq_ctrl_if.master    mem
);

   import mem_pkg::*;

   localparam int unsigned LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   state_t            state;
   logic [LAT_W-1:0]  lat_cnt;
   logic [ADDR_W-1:0] ptr;
   logic              wr_go;

   assign rd_ready = (state == FILL) && !wipe_req;
   assign wr_ready = (state == FILL) && !wipe_req && !rd_req && !full;
   assign wr_go    = wr_valid && wr_ready;

   mem_fill_ptr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fill_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_go),
      .clr   (state == WIPE),
      .ptr   (ptr),
      .count (wr_count),
      .full  (full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= FILL;
         lat_cnt        <= '0;
         rd_valid       <= 1'b0;
         rd_a           <= '0;
         rd_b           <= '0;
         mem.mem_addr_a <= '0;
         mem.mem_addr_b <= '0;
         mem.mem_a      <= '0;
         mem.mem_b      <= '0;
         mem.mem_rw     <= 1'b0;
         mem.mem_wipe   <= 1'b0;
      end else begin
         rd_valid     <= 1'b0;
         mem.mem_rw   <= 1'b0;
         mem.mem_wipe <= 1'b0;
         case (state)
            FILL: begin
               if (wipe_req) begin
                  mem.mem_wipe <= 1'b1;
                  state        <= WIPE;
               end else if (rd_req) begin
                  mem.mem_addr_a <= rd_addr_a;
                  mem.mem_addr_b <= rd_addr_b;
                  lat_cnt        <= LAT_W'(RD_LAT);
                  state          <= RD_WAIT;
               end else if (wr_go) begin
                  mem.mem_rw     <= 1'b1;
                  mem.mem_addr_a <= ptr;
                  mem.mem_addr_b <= ptr;
                  mem.mem_a      <= wr_a;
                  mem.mem_b      <= wr_b;
               end
            end
            // A held wipe_req keeps the memory wipe asserted instead of bouncing through FILL.
            WIPE: begin
               rd_a <= '0;
               rd_b <= '0;
               if (wipe_req) begin
                  mem.mem_wipe <= 1'b1;
               end else begin
                  state <= FILL;
               end
            end
            RD_WAIT: begin
               if (lat_cnt == '0) begin
                  rd_a     <= mem.mem_a_out;
                  rd_b     <= mem.mem_b_out;
                  rd_valid <= 1'b1;
                  state    <= FILL;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl driving a behavioural dual-port 16x8 memory block.
module tb_mem_seq_ctrl;

   localparam int unsigned RD_LAT = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wipe_req = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_a = '0;
   logic [7:0] wr_b = '0;
   logic       rd_req = 1'b0;
   logic       rd_ready;
   logic [3:0] rd_addr_a = '0;
   logic [3:0] rd_addr_b = '0;
   logic       rd_valid;
   logic [7:0] rd_a;
   logic [7:0] rd_b;
   logic [4:0] wr_count;
   logic       full;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_seq_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   mem_seq_ctrl #(
      .DATA_W (8),
      .ADDR_W (4),
      .DEPTH  (16),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wipe_req  (wipe_req),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_a      (wr_a),
      .wr_b      (wr_b),
      .rd_req    (rd_req),
      .rd_ready  (rd_ready),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_valid  (rd_valid),
      .rd_a      (rd_a),
      .rd_b      (rd_b),
      .wr_count  (wr_count),
      .full      (full),
      .mem       (bus.master)
   );

   // Memory block: separate A/B banks, write on sampled rw=1, one-clock registered read.
   logic [7:0] bank_a [16];
   logic [7:0] bank_b [16];
   logic [7:0] m_a_out;
   logic [7:0] m_b_out;
   assign bus.mem_a_out = m_a_out;
   assign bus.mem_b_out = m_b_out;

   always @(posedge clk) begin
      if (!reset || bus.mem_wipe) begin
         for (int i = 0; i < 16; i++) begin
            bank_a[i] <= '0;
            bank_b[i] <= '0;
         end
         m_a_out <= '0;
         m_b_out <= '0;
      end else if (bus.mem_rw) begin
         bank_a[bus.mem_addr_a] <= bus.mem_a;
         bank_b[bus.mem_addr_b] <= bus.mem_b;
      end else begin
         m_a_out <= bank_a[bus.mem_addr_a];
         m_b_out <= bank_b[bus.mem_addr_b];
      end
   end

   typedef struct {
      logic [3:0] addr_a;
      logic [3:0] addr_b;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } rd_vec_t;

   logic [7:0] pa [16] = '{8'h54, 8'h16, 8'h83, 8'h29, 8'hc7, 8'h0b, 8'he5, 8'h71,
                           8'h3d, 8'h9a, 8'ha8, 8'hf0, 8'h12, 8'h66, 8'hbc, 8'h4e};
   logic [7:0] pb [16] = '{8'ha3, 8'h32, 8'hf2, 8'h5c, 8'h08, 8'hd1, 8'h47, 8'h9e,
                           8'hb6, 8'h2a, 8'he3, 8'h10, 8'h7f, 8'hc5, 8'h81, 8'h98};
   rd_vec_t rd_vec [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [3:0] aa, input logic [3:0] ab,
                          input logic [7:0] ea, input logic [7:0] eb, input string tag);
      int lat;
      rd_req    = 1'b1;
      rd_addr_a = aa;
      rd_addr_b = ab;
      #1;
      chk({tag, " rd_ready"}, 32'(rd_ready), 32'd1);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      chk({tag, " mem_addr_a"}, 32'(bus.mem_addr_a), 32'(aa));
      chk({tag, " mem_addr_b"}, 32'(bus.mem_addr_b), 32'(ab));
      chk({tag, " mem_rw"}, 32'(bus.mem_rw), 32'd0);
      chk({tag, " rd_ready busy"}, 32'(rd_ready), 32'd0);
      lat = 0;
      while (!rd_valid && lat < 8) begin
         step();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(RD_LAT + 1));
      chk({tag, " rd_a"}, 32'(rd_a), 32'(ea));
      chk({tag, " rd_b"}, 32'(rd_b), 32'(eb));
      step();
      chk({tag, " rd_valid pulse"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;

      #10;
      reset = 1'b1;
      #1;
      chk("reset mem_addr_a", 32'(bus.mem_addr_a), 32'd0);
      chk("reset mem_addr_b", 32'(bus.mem_addr_b), 32'd0);
      chk("reset mem_a", 32'(bus.mem_a), 32'd0);
      chk("reset mem_b", 32'(bus.mem_b), 32'd0);
      chk("reset mem_rw", 32'(bus.mem_rw), 32'd0);
      chk("reset mem_wipe", 32'(bus.mem_wipe), 32'd0);
      chk("reset wr_count", 32'(wr_count), 32'd0);
      chk("reset full", 32'(full), 32'd0);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);
      chk("reset wr_ready", 32'(wr_ready), 32'd1);
      chk("reset rd_ready", 32'(rd_ready), 32'd1);

      step();
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1;
         wr_a     = pa[i];
         wr_b     = pb[i];
         #1;
         chk("fill wr_ready", 32'(wr_ready), 32'd1);
         step();
         chk("fill mem_addr_a", 32'(bus.mem_addr_a), 32'(i));
         chk("fill mem_addr_b", 32'(bus.mem_addr_b), 32'(i));
         chk("fill mem_rw", 32'(bus.mem_rw), 32'd1);
         chk("fill mem_a", 32'(bus.mem_a), 32'(pa[i]));
         chk("fill mem_b", 32'(bus.mem_b), 32'(pb[i]));
      end
      chk("fill wr_count", 32'(wr_count), 32'd16);
      chk("fill full", 32'(full), 32'd1);
      wr_a = 8'hff;
      wr_b = 8'hee;
      #1;
      chk("full wr_ready", 32'(wr_ready), 32'd0);
      step();
      chk("full mem_rw", 32'(bus.mem_rw), 32'd0);
      chk("full wr_count sat", 32'(wr_count), 32'd16);
      wr_valid = 1'b0;

      rd_vec[0] = '{4'h3, 4'h5, pa[3], pb[5]};
      rd_vec[1] = '{4'hf, 4'he, pa[15], pb[14]};
      rd_vec[2] = '{4'h0, 4'h1, pa[0], pb[1]};
      for (int i = 0; i < 3; i++) begin
         do_read(rd_vec[i].addr_a, rd_vec[i].addr_b, rd_vec[i].exp_a, rd_vec[i].exp_b, "table read");
      end

      // All three requests at once: only the wipe is taken.
      wr_valid = 1'b1;
      rd_req   = 1'b1;
      wipe_req = 1'b1;
      #1;
      chk("wipe wr_ready", 32'(wr_ready), 32'd0);
      chk("wipe rd_ready", 32'(rd_ready), 32'd0);
      step();
      wr_valid = 1'b0;
      rd_req   = 1'b0;
      wipe_req = 1'b0;
      chk("wipe mem_wipe on", 32'(bus.mem_wipe), 32'd1);
      chk("wipe mem_rw", 32'(bus.mem_rw), 32'd0);
      step();
      chk("wipe mem_wipe off", 32'(bus.mem_wipe), 32'd0);
      chk("wipe wr_count", 32'(wr_count), 32'd0);
      chk("wipe full", 32'(full), 32'd0);
      chk("wipe rd_a", 32'(rd_a), 32'd0);
      chk("wipe rd_b", 32'(rd_b), 32'd0);
      step();
      chk("wipe mem_wipe single", 32'(bus.mem_wipe), 32'd0);
      do_read(4'h3, 4'h3, 8'h00, 8'h00, "post-wipe read");

      // Read beats write; stalled write goes out right after the read completes.
      wr_valid  = 1'b1;
      wr_a      = 8'h5a;
      wr_b      = 8'hc3;
      rd_req    = 1'b1;
      rd_addr_a = 4'h2;
      rd_addr_b = 4'h3;
      #1;
      chk("prio wr_ready", 32'(wr_ready), 32'd0);
      chk("prio rd_ready", 32'(rd_ready), 32'd1);
      step();
      rd_req = 1'b0;
      chk("prio mem_rw", 32'(bus.mem_rw), 32'd0);
      chk("prio wr_count", 32'(wr_count), 32'd0);
      chk("prio wr_ready busy", 32'(wr_ready), 32'd0);
      lat = 0;
      while (!rd_valid && lat < 8) begin
         step();
         lat++;
      end
      chk("prio latency", 32'(lat), 32'(RD_LAT + 1));
      chk("prio wr_ready back", 32'(wr_ready), 32'd1);
      step();
      wr_valid = 1'b0;
      chk("prio write mem_rw", 32'(bus.mem_rw), 32'd1);
      chk("prio write addr", 32'(bus.mem_addr_a), 32'd0);
      chk("prio write mem_a", 32'(bus.mem_a), 32'h5a);
      chk("prio write count", 32'(wr_count), 32'd1);

      // Read-after-write to the same entry on the next cycle.
      wr_valid = 1'b1;
      wr_a     = 8'h11;
      wr_b     = 8'h22;
      step();
      wr_valid = 1'b0;
      do_read(4'h1, 4'h0, 8'h11, 8'hc3, "raw read");
      chk("raw wr_count", 32'(wr_count), 32'd2);

      // Reset during RD_WAIT must abort the read.
      rd_req    = 1'b1;
      rd_addr_a = 4'h1;
      rd_addr_b = 4'h1;
      step();
      rd_req = 1'b0;
      reset  = 1'b0;
      #1;
      chk("abort rd_valid", 32'(rd_valid), 32'd0);
      chk("abort wr_count", 32'(wr_count), 32'd0);
      seen = 0;
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rd_valid) seen++;
      end
      chk("abort no rd_valid", 32'(seen), 32'd0);
      chk("abort wr_count after", 32'(wr_count), 32'd0);
      chk("abort wr_ready", 32'(wr_ready), 32'd1);
      chk("abort rd_ready", 32'(rd_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Upstream sequencer for the dual-port 16x8 memory interface block. It drives that block's addr_a/addr_b, a/b, rw and wipe inputs, and captures its a_out/b_out.
- Turns a valid/ready write stream of byte pairs into auto-incrementing address writes. Turns a read-request handshake into timed readback with a valid pulse.
- Removes hand-sequenced address/rw stimulus from higher-level logic.

Parameters:
- DATA_W, 8, width of each port data byte
- ADDR_W, 4, memory address width
- DEPTH, 16, number of entries; must equal 2**ADDR_W
- RD_LAT, 1, memory read latency in clocks, from the edge that samples the address to the edge at which a_out/b_out are valid

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wipe_req  in  1  request to clear memory and write pointer
- wr_valid  in  1  write pair offered
- wr_ready  out  1  write pair accepted when high with wr_valid
- wr_a  in  DATA_W  port-A write byte
- wr_b  in  DATA_W  port-B write byte
- rd_req  in  1  read request
- rd_ready  out  1  read request accepted when high with rd_req
- rd_addr_a  in  ADDR_W  port-A read address
- rd_addr_b  in  ADDR_W  port-B read address
- rd_valid  out  1  one-cycle pulse: rd_a/rd_b updated
- rd_a  out  DATA_W  captured port-A read data
- rd_b  out  DATA_W  captured port-B read data
- wr_count  out  ADDR_W+1  entries written since last wipe/reset (0..DEPTH)
- full  out  1  wr_count == DEPTH
- mem_addr_a  out  ADDR_W  to memory addr_a
- mem_addr_b  out  ADDR_W  to memory addr_b
- mem_a  out  DATA_W  to memory a
- mem_b  out  DATA_W  to memory b
- mem_rw  out  1  to memory rw; 1 = write, 0 = read
- mem_wipe  out  1  to memory wipe
- mem_a_out  in  DATA_W  from memory a_out
- mem_b_out  in  DATA_W  from memory b_out

Behaviour:
- Reset (reset low, asynchronous):
  - state FILL
  - all mem_* outputs 0; mem_rw = 0 (read, so no spurious write)
  - wr_count = 0, write pointer = 0
  - rd_valid = 0, rd_a = 0, rd_b = 0
  - reset asserted mid-read aborts the read; no rd_valid is produced
- All mem_* outputs are registered. The memory sees a command one edge after the accepting edge N, i.e. it samples at edge N+1.
- States: FILL, WIPE, RD_WAIT.
- FILL, combinational ready outputs:
  - rd_ready = !wipe_req
  - wr_ready = !wipe_req && !rd_req && !full
  - Priority: wipe > read > write.
- FILL, wipe_req high: go WIPE.
- FILL, read accepted at edge N:
  - mem_rw <= 0, mem_addr_a <= rd_addr_a, mem_addr_b <= rd_addr_b
  - load latency counter with RD_LAT; go RD_WAIT
- FILL, write accepted at edge N:
  - mem_rw <= 1; mem_addr_a = mem_addr_b <= write pointer; mem_a <= wr_a, mem_b <= wr_b
  - pointer increments, wrapping DEPTH-1 -> 0; wr_count increments
  - back-to-back writes allowed, one per cycle
- FILL, no handshake: mem_rw <= 0; addresses and data hold.
- Full condition: wr_valid is ignored; wr_count saturates at DEPTH; pointer stays at 0. Only wipe re-enables writes. Reads remain allowed.
- RD_WAIT:
  - rd_ready = 0, wr_ready = 0; mem_rw stays 0
  - counter decrements each edge
  - at edge N+1+RD_LAT: rd_a <= mem_a_out, rd_b <= mem_b_out, rd_valid <= 1 for exactly one cycle; return to FILL
  - wipe_req is ignored until back in FILL
- WIPE (one cycle):
  - mem_wipe <= 1 and mem_rw <= 0 for exactly one cycle
  - wr_count, pointer, rd_a, rd_b cleared
  - next state FILL; mem_wipe returns to 0
  - if wipe_req is held high, WIPE repeats
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data, provided the memory writes at the edge it samples rw = 1.
- Width rules: wr_count is ADDR_W+1 bits, never exceeds DEPTH. Pointer is ADDR_W bits.

Decomposition:
- Package mem_pkg holds DATA_W, ADDR_W, DEPTH, RD_LAT defaults and the state enum {FILL, WIPE, RD_WAIT}.
- One sub-module, mem_fill_ptr: pointer plus saturating count, with inc/clr/full. Everything else stays in mem_seq_ctrl.
- Bench instantiates mem_seq_ctrl together with the existing memory interface block.

Test Plan:
- Reset low 10 ns, then high -> all mem_* = 0, wr_count = 0, full = 0, rd_valid = 0; wr_ready = 1 with no requests.
- Stream 16 pairs (54/a3, 16/32, 83/F2 ... 4e/98) with wr_valid held -> one accepted per cycle; mem_addr 0..F in order; wr_count = 16, full = 1; 17th pair gets wr_ready = 0 and the memory is not written.
- After fill, read A = 3, B = 5 -> rd_valid pulses RD_LAT+1 edges after accept, with the values stored at entries 3 and 5. Then read A = F, B = E, then A = 0, B = 1 -> correct bytes each time; rd_ready low during RD_WAIT.
- wr_valid, rd_req and wipe_req all high in one cycle -> only WIPE taken; mem_wipe high exactly 1 cycle, then wr_count = 0, full = 0, rd_a/rd_b = 0; a following read of address 3 returns 00/00.
- wr_valid and rd_req both high in FILL -> read wins, write stalled (wr_ready = 0); write accepted the cycle after returning to FILL.
- Reset pulled low during RD_WAIT -> rd_valid never asserts; state FILL, wr_count = 0 after release.
